// File: rtl/ft245_pkg.sv
// Shared constants and types for the FT232H synchronous 245 device model.
package ft245_pkg;

  localparam int FT_BYTE_W = 8;

  // Level of RD#/WR#/OE# when the host is asserting the strobe.
  localparam logic STROBE_ON = 1'b0;

  localparam int DEF_DEPTH_LOG2  = 9;
  localparam int DEF_TXE_HOLDOFF = 4;

  typedef logic [FT_BYTE_W-1:0] ft_byte_t;

endpackage

// File: rtl/ft245_sync_device_if.sv
// FT245 synchronous FIFO bus plus the two USB-side byte streams.
//
// Stream handshake: a byte moves on a rising ft_clk edge where valid and
// ready are both high. The source holds data stable while valid is high and
// ready is low; valid never depends on ready.
interface ft245_sync_device_if;
  import ft245_pkg::*;

  // FT245 bus, as seen from the chip
  logic     ft_rxf_n;
  logic     ft_txe_n;
  logic     ft_oe_n;
  logic     ft_rd_n;
  logic     ft_wr_n;
  ft_byte_t ft_data_i;
  ft_byte_t ft_data_o;
  logic     ft_data_oe;

  // USB-OUT stream into the device (toward the host)
  ft_byte_t s_data;
  logic     s_valid;
  logic     s_ready;

  // USB-IN stream out of the device (from the host)
  ft_byte_t m_data;
  logic     m_valid;
  logic     m_ready;

  // Host side: FPGA master on the bus plus the USB stream endpoints.
  modport master (
    output ft_oe_n, ft_rd_n, ft_wr_n, ft_data_i, s_data, s_valid, m_ready,
    input  ft_rxf_n, ft_txe_n, ft_data_o, ft_data_oe, s_ready, m_data, m_valid
  );

  // Chip side: the device responder.
  modport slave (
    input  ft_oe_n, ft_rd_n, ft_wr_n, ft_data_i, s_data, s_valid, m_ready,
    output ft_rxf_n, ft_txe_n, ft_data_o, ft_data_oe, s_ready, m_data, m_valid
  );

endinterface

// File: rtl/ft_dev_fifo.sv
// Single-clock first-word-fall-through byte queue with registered flags.
// Push on full and pop on empty are ignored.
module ft_dev_fifo #(
  parameter int DEPTH_LOG2 = 9,
  parameter int W          = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [W-1:0]          mem_q [0:(1<<DEPTH_LOG2)-1];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic                  push_ok, pop_ok;

  // Next-state for pointers, occupancy and the flags derived from it.
  always_comb begin
    push_ok  = push_i & ~full_q;
    pop_ok   = pop_i & ~empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
    count_d = count_q + {{DEPTH_LOG2{1'b0}}, push_ok} - {{DEPTH_LOG2{1'b0}}, pop_ok};
    empty_d = (count_d == '0);
    full_d  = (count_d == DEPTH_CNT);
  end

  // Control state; reset empties the queue.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign empty_o = empty_q;
  assign full_o  = full_q;

endmodule

// File: rtl/ft245_sync_device.sv
// Chip-end responder for the FT232H synchronous 245 FIFO bus. The RX queue
// feeds host reads, the TX queue collects host writes; both are bridged to
// valid/ready byte streams on the USB side.
module ft245_sync_device
  import ft245_pkg::*;
#(
  parameter int DEPTH_LOG2  = DEF_DEPTH_LOG2,
  parameter int TXE_HOLDOFF = DEF_TXE_HOLDOFF
) (
  input  logic                   ft_clk,
  input  logic                   rst_n,
  ft245_sync_device_if.slave     bus,
  output logic                   rd_underrun,
  output logic                   wr_overrun,
  output logic                   bus_conflict,
  output logic [31:0]            rx_count,
  output logic [31:0]            tx_count
);

  localparam int HW = (TXE_HOLDOFF < 1) ? 1 : $clog2(TXE_HOLDOFF + 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(TXE_HOLDOFF);

  ft_byte_t rx_head, tx_head;
  logic     rx_empty, rx_full, tx_empty, tx_full;
  logic     oe_on, rd_strobe, wr_strobe;
  logic     rx_push, rx_pop, tx_push, tx_pop;
  logic     txe_n;

  logic [HW-1:0] holdoff_q, holdoff_d;
  logic          rd_underrun_q, rd_underrun_d;
  logic          wr_overrun_q, wr_overrun_d;
  logic          bus_conflict_q, bus_conflict_d;
  logic [31:0]   rx_count_q, rx_count_d;
  logic [31:0]   tx_count_q, tx_count_d;

  // Strobe decode. A write while the device drives the bus is a conflict
  // and is never accepted, regardless of TXE#.
  assign oe_on     = (bus.ft_oe_n == STROBE_ON);
  assign rd_strobe = (bus.ft_rd_n == STROBE_ON) & oe_on;
  assign wr_strobe = (bus.ft_wr_n == STROBE_ON);

  assign txe_n   = tx_full | (holdoff_q != '0);
  assign rx_push = bus.s_valid & bus.s_ready;
  assign rx_pop  = rd_strobe & ~rx_empty;
  assign tx_push = wr_strobe & ~oe_on & ~txe_n;
  assign tx_pop  = bus.m_valid & bus.m_ready;

  ft_dev_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .W(FT_BYTE_W)) rx_q (
    .clk_i   (ft_clk),
    .rst_ni  (rst_n),
    .push_i  (rx_push),
    .wdata_i (bus.s_data),
    .pop_i   (rx_pop),
    .rdata_o (rx_head),
    .empty_o (rx_empty),
    .full_o  (rx_full)
  );

  ft_dev_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .W(FT_BYTE_W)) tx_q (
    .clk_i   (ft_clk),
    .rst_ni  (rst_n),
    .push_i  (tx_push),
    .wdata_i (bus.ft_data_i),
    .pop_i   (tx_pop),
    .rdata_o (tx_head),
    .empty_o (tx_empty),
    .full_o  (tx_full)
  );

  // Holdoff reload when the TX queue leaves full, error pulses, byte counters.
  always_comb begin
    holdoff_d = holdoff_q;
    if (tx_full & tx_pop)    holdoff_d = HOLD_INIT;
    else if (holdoff_q != '0) holdoff_d = holdoff_q - HW'(1);
    rd_underrun_d  = rd_strobe & rx_empty;
    bus_conflict_d = wr_strobe & oe_on;
    wr_overrun_d   = wr_strobe & ~oe_on & txe_n;
    rx_count_d     = rx_count_q + {31'd0, rx_pop};
    tx_count_d     = tx_count_q + {31'd0, tx_push};
  end

  // Status registers; reset starts the TXE# holdoff window.
  always_ff @(posedge ft_clk or negedge rst_n) begin
    if (!rst_n) begin
      holdoff_q      <= HOLD_INIT;
      rd_underrun_q  <= 1'b0;
      wr_overrun_q   <= 1'b0;
      bus_conflict_q <= 1'b0;
      rx_count_q     <= '0;
      tx_count_q     <= '0;
    end else begin
      holdoff_q      <= holdoff_d;
      rd_underrun_q  <= rd_underrun_d;
      wr_overrun_q   <= wr_overrun_d;
      bus_conflict_q <= bus_conflict_d;
      rx_count_q     <= rx_count_d;
      tx_count_q     <= tx_count_d;
    end
  end

  // Bus drive is released the moment reset asserts, not at the next edge.
  assign bus.ft_rxf_n   = rx_empty;
  assign bus.ft_txe_n   = txe_n;
  assign bus.ft_data_o  = rx_empty ? '0 : rx_head;
  assign bus.ft_data_oe = oe_on & rst_n;
  assign bus.s_ready    = ~rx_full & rst_n;
  assign bus.m_valid    = ~tx_empty;
  assign bus.m_data     = tx_empty ? '0 : tx_head;

  assign rd_underrun  = rd_underrun_q;
  assign wr_overrun   = wr_overrun_q;
  assign bus_conflict = bus_conflict_q;
  assign rx_count     = rx_count_q;
  assign tx_count     = tx_count_q;

endmodule

// File: tb/tb_ft245_sync_device.sv
// Bench for ft245_sync_device: directed bus scenarios followed by random
// traffic, with byte ordering checked by monitors against expected queues.
module tb_ft245_sync_device;

  logic        ft_clk;
  logic        rst_n;
  logic        rd_underrun, wr_overrun, bus_conflict;
  logic [31:0] rx_count, tx_count;

  ft245_sync_device_if bus ();

  ft245_sync_device dut (
    .ft_clk       (ft_clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .rd_underrun  (rd_underrun),
    .wr_overrun   (wr_overrun),
    .bus_conflict (bus_conflict),
    .rx_count     (rx_count),
    .tx_count     (tx_count)
  );

  // ---------------- clock / reset ----------------
  initial ft_clk = 1'b0;
  always #8 ft_clk = ~ft_clk;

  // ---------------- scoreboard ----------------
  logic [7:0] rx_exp_q[$];
  logic [7:0] tx_exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // RX monitor: every byte the host takes must be the oldest one pushed.
  always @(negedge ft_clk) begin
    if (rst_n && !bus.ft_oe_n && !bus.ft_rd_n && !bus.ft_rxf_n) begin
      if (rx_exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rx_extra_pop: got %0h expected none at %0t", bus.ft_data_o, $time);
      end else begin
        check("rx_data", 32'(bus.ft_data_o), 32'(rx_exp_q.pop_front()));
      end
    end
  end

  // TX monitor: every byte leaving on m_* must be the oldest accepted write.
  always @(negedge ft_clk) begin
    if (rst_n && bus.m_valid && bus.m_ready) begin
      if (tx_exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL tx_extra_pop: got %0h expected none at %0t", bus.m_data, $time);
      end else begin
        check("tx_data", 32'(bus.m_data), 32'(tx_exp_q.pop_front()));
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge ft_clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.ft_oe_n   = 1'b1;
    bus.ft_rd_n   = 1'b1;
    bus.ft_wr_n   = 1'b1;
    bus.ft_data_i = 8'h00;
    bus.s_valid   = 1'b0;
    bus.s_data    = 8'h00;
    bus.m_ready   = 1'b0;
  endtask

  // Enter reset with OE# low to prove the data enable is gated, check the
  // reset values, then release at the start of a cycle.
  task automatic do_reset();
    tick();
    idle_bus();
    bus.ft_oe_n = 1'b0;
    rst_n = 1'b0;
    rx_exp_q.delete();
    tx_exp_q.delete();
    #2;
    check("rst_rxf_n", 32'(bus.ft_rxf_n), 32'd1);
    check("rst_txe_n", 32'(bus.ft_txe_n), 32'd1);
    check("rst_data_oe", 32'(bus.ft_data_oe), 32'd0);
    check("rst_data_o", 32'(bus.ft_data_o), 32'd0);
    check("rst_s_ready", 32'(bus.s_ready), 32'd0);
    check("rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("rst_pulses", 32'({rd_underrun, wr_overrun, bus_conflict}), 32'd0);
    check("rst_rx_count", rx_count, 32'd0);
    check("rst_tx_count", tx_count, 32'd0);
    repeat (3) tick();
    bus.ft_oe_n = 1'b1;
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] b;
  logic       s_acc;
  int         rx_pushed;
  int         tx_written;

  initial begin
    rst_n = 1'b1;
    idle_bus();

    // Reset, then TXE# holdoff with an early write that must be dropped.
    do_reset();
    bus.ft_wr_n   = 1'b0;
    bus.ft_data_i = 8'hAA;
    @(negedge ft_clk);
    check("hold_txe_k0", 32'(bus.ft_txe_n), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      bus.ft_wr_n = 1'b1;
      @(negedge ft_clk);
      check("hold_txe", 32'(bus.ft_txe_n), 32'(k < 4));
      if (k == 1) begin
        check("early_wr_overrun", 32'(wr_overrun), 32'd1);
        check("early_tx_count", tx_count, 32'd0);
      end
    end
    check("early_m_valid", 32'(bus.m_valid), 32'd0);

    // 16 bytes in on s_*, read back in order over the bus.
    tick();
    for (int i = 0; i < 16; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 8'(i);
      rx_exp_q.push_back(8'(i));
      @(negedge ft_clk);
      check("t1_s_ready", 32'(bus.s_ready), 32'd1);
      tick();
    end
    bus.s_valid = 1'b0;
    bus.ft_oe_n = 1'b0;
    bus.ft_rd_n = 1'b0;
    @(negedge ft_clk);
    check("t1_rxf_low", 32'(bus.ft_rxf_n), 32'd0);
    check("t1_data_oe", 32'(bus.ft_data_oe), 32'd1);
    repeat (16) tick();
    bus.ft_rd_n = 1'b1;
    bus.ft_oe_n = 1'b1;
    @(negedge ft_clk);
    check("t1_rxf_high", 32'(bus.ft_rxf_n), 32'd1);
    check("t1_rx_count", rx_count, 32'd16);
    check("t1_rx_left", 32'(rx_exp_q.size()), 32'd0);

    // Read strobe against an empty RX queue.
    tick();
    bus.ft_oe_n = 1'b0;
    bus.ft_rd_n = 1'b0;
    tick();
    bus.ft_oe_n = 1'b1;
    bus.ft_rd_n = 1'b1;
    @(negedge ft_clk);
    check("t5_rd_underrun", 32'(rd_underrun), 32'd1);
    check("t5_rx_count", rx_count, 32'd16);
    tick();
    @(negedge ft_clk);
    check("t5_pulse_width", 32'(rd_underrun), 32'd0);

    // Write while OE# is low: conflict, byte ignored.
    tick();
    bus.ft_oe_n   = 1'b0;
    bus.ft_wr_n   = 1'b0;
    bus.ft_data_i = 8'h55;
    @(negedge ft_clk);
    check("t4_data_oe", 32'(bus.ft_data_oe), 32'd1);
    check("t4_txe_low", 32'(bus.ft_txe_n), 32'd0);
    tick();
    bus.ft_wr_n = 1'b1;
    bus.ft_oe_n = 1'b1;
    @(negedge ft_clk);
    check("t4_bus_conflict", 32'(bus_conflict), 32'd1);
    check("t4_no_overrun", 32'(wr_overrun), 32'd0);
    check("t4_tx_count", tx_count, 32'd0);
    check("t4_m_valid", 32'(bus.m_valid), 32'd0);

    // Fill the TX queue, overrun it, then one pop reopens TXE# after holdoff.
    bus.m_ready = 1'b0;
    for (int i = 0; i < 512; i++) begin
      tick();
      b = 8'($urandom);
      bus.ft_wr_n   = 1'b0;
      bus.ft_data_i = b;
      tx_exp_q.push_back(b);
    end
    tick();
    bus.ft_data_i = 8'hEE;
    @(negedge ft_clk);
    check("t2_txe_full", 32'(bus.ft_txe_n), 32'd1);
    check("t2_tx_count", tx_count, 32'd512);
    tick();
    bus.ft_wr_n = 1'b1;
    @(negedge ft_clk);
    check("t2_wr_overrun", 32'(wr_overrun), 32'd1);
    check("t2_tx_count_513", tx_count, 32'd512);
    check("t2_m_valid", 32'(bus.m_valid), 32'd1);
    tick();
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
    @(negedge ft_clk);
    check("t2_hold_k0", 32'(bus.ft_txe_n), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      @(negedge ft_clk);
      check("t2_hold", 32'(bus.ft_txe_n), 32'(k < 4));
    end
    tick();
    bus.m_ready = 1'b1;
    for (int t = 0; t < 700; t++) begin
      @(negedge ft_clk);
      if (tx_exp_q.size() == 0) break;
    end
    check("t2_drain", 32'(tx_exp_q.size()), 32'd0);
    tick();
    bus.m_ready = 1'b0;

    // Reset in the middle of a read burst with bytes still queued.
    for (int i = 0; i < 8; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 8'hA0 + 8'(i);
      rx_exp_q.push_back(8'hA0 + 8'(i));
      tick();
    end
    bus.s_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.ft_wr_n   = 1'b0;
      bus.ft_data_i = 8'hC0 + 8'(i);
      tick();
    end
    bus.ft_wr_n = 1'b1;
    @(negedge ft_clk);
    check("t6_m_valid_pre", 32'(bus.m_valid), 32'd1);
    tick();
    bus.ft_oe_n = 1'b0;
    bus.ft_rd_n = 1'b0;
    repeat (3) tick();
    #3;
    rst_n = 1'b0;
    rx_exp_q.delete();
    #1;
    check("t6_async_rxf_n", 32'(bus.ft_rxf_n), 32'd1);
    check("t6_async_data_oe", 32'(bus.ft_data_oe), 32'd0);
    repeat (2) tick();
    bus.ft_rd_n = 1'b1;
    bus.ft_oe_n = 1'b1;
    rst_n = 1'b1;
    repeat (5) tick();
    @(negedge ft_clk);
    check("t6_rxf_n", 32'(bus.ft_rxf_n), 32'd1);
    check("t6_m_valid", 32'(bus.m_valid), 32'd0);
    check("t6_rx_count", rx_count, 32'd0);
    check("t6_tx_count", tx_count, 32'd0);
    check("t6_s_ready", 32'(bus.s_ready), 32'd1);

    // Random traffic on all four sides at once.
    rx_pushed  = 0;
    tx_written = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge ft_clk);
      s_acc = bus.s_valid && bus.s_ready;
      tick();
      if (s_acc) begin
        rx_exp_q.push_back(bus.s_data);
        rx_pushed++;
      end
      if (!bus.s_valid || s_acc) begin
        bus.s_valid = ($urandom_range(0, 2) != 0);
        bus.s_data  = 8'($urandom);
      end
      if (cyc < 1500) bus.m_ready = ($urandom_range(0, 3) == 0);
      else            bus.m_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 2))
        0: begin
          bus.ft_oe_n = 1'b1;
          bus.ft_rd_n = 1'b1;
          bus.ft_wr_n = 1'b1;
        end
        1: begin
          bus.ft_oe_n = 1'b0;
          bus.ft_rd_n = 1'b0;
          bus.ft_wr_n = 1'b1;
        end
        default: begin
          bus.ft_oe_n = 1'b1;
          bus.ft_rd_n = 1'b1;
          if (!bus.ft_txe_n) begin
            b = 8'($urandom);
            bus.ft_wr_n   = 1'b0;
            bus.ft_data_i = b;
            tx_exp_q.push_back(b);
            tx_written++;
          end else begin
            bus.ft_wr_n = 1'b1;
          end
        end
      endcase
    end
    @(negedge ft_clk);
    s_acc = bus.s_valid && bus.s_ready;
    tick();
    if (s_acc) begin
      rx_exp_q.push_back(bus.s_data);
      rx_pushed++;
    end
    bus.s_valid = 1'b0;
    bus.ft_wr_n = 1'b1;
    bus.ft_oe_n = 1'b0;
    bus.ft_rd_n = 1'b0;
    bus.m_ready = 1'b1;
    for (int t = 0; t < 2000; t++) begin
      @(negedge ft_clk);
      if (rx_exp_q.size() == 0 && tx_exp_q.size() == 0) break;
    end
    check("rand_drain", 32'(rx_exp_q.size() + tx_exp_q.size()), 32'd0);
    tick();
    idle_bus();
    repeat (2) tick();
    @(negedge ft_clk);
    check("rand_rx_count", rx_count, 32'(rx_pushed));
    check("rand_tx_count", tx_count, 32'(tx_written));
    check("rand_rxf_n", 32'(bus.ft_rxf_n), 32'd1);
    check("rand_m_valid", 32'(bus.m_valid), 32'd0);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
